// File: rtl/fifo_arb_pkg.sv
// Shared lane constants and one-hot state encoding for the four-lane FIFO arbiter.
package fifo_arb_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_IDLE   = 4'b0010,
        ST_ACTIVE = 4'b0100,
        ST_STALL  = 4'b1000
    } state_t;

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible lane after ptr wins (ptr itself last).
// Zero latency, no backpressure; any=0 means no grant.
module rr_pick
    import fifo_arb_pkg::*;
(
    input  logic [NUM_LANES-1:0] eligible,
    input  logic [LANE_W-1:0]    ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [LANE_W-1:0]    grant_idx,
    output logic                 any
);

    logic [LANE_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        any       = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            w_idx = LANE_W'(int'(ptr) + k);
            if (!any && eligible[w_idx]) begin
                any          = 1'b1;
                grant_idx    = w_idx;
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Four-lane round-robin drain of source FIFOs into one stream; FIFO_ARB_STATS_EN adds per-lane counters.
// Latency: pop registered at edge N, word on data_out at edge N+2.
// Backpressure: dest_almost_full stops new pops at once; up to 2 in-flight words still drain.
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk8f,
    input  logic                 reset,
    input  logic [3:0]           fifo_empty,
    input  logic [DATA_W-1:0]    fifo_dout_0,
    input  logic [DATA_W-1:0]    fifo_dout_1,
    input  logic [DATA_W-1:0]    fifo_dout_2,
    input  logic [DATA_W-1:0]    fifo_dout_3,
    input  logic                 dest_almost_full,
    output logic [3:0]           fifo_pop,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid_out,
    output logic [1:0]           lane_out,
`ifdef FIFO_ARB_STATS_EN
    output logic                 idle_out,
    output logic [4*CNT_W-1:0]   stats_out
`else
    output logic                 idle_out
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_fifo_pop;
    logic [3:0]          w_pop_nxt;
    logic [LANE_W-1:0]   r_ptr;
    logic [LANE_W-1:0]   w_ptr_nxt;
    logic                r_s1_vld;
    logic [LANE_W-1:0]   r_s1_lane;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_valid_out;
    logic [LANE_W-1:0]   r_lane_out;

    logic                w_nonempty;
    logic [3:0]          w_eligible;
    logic [3:0]          w_grant;
    logic [LANE_W-1:0]   w_grant_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_dout_sel;

    assign w_nonempty = ~&fifo_empty;
    // Empty flags lag a pop by one cycle, so the lane just popped must sit out.
    assign w_eligible = ~fifo_empty & ~r_fifo_pop;

    rr_pick u_rr_pick (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop_nxt   = '0;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            ST_RESET: w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (w_nonempty && !dest_almost_full)
                    w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (dest_almost_full) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    if (!w_nonempty)
                        w_state_nxt = ST_IDLE;
                    if (w_any) begin
                        w_pop_nxt = w_grant;
                        w_ptr_nxt = w_grant_idx;
                    end
                end
            end
            ST_STALL: begin
                if (!dest_almost_full)
                    w_state_nxt = w_nonempty ? ST_ACTIVE : ST_IDLE;
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        w_dout_sel = '0;
        case (r_s1_lane)
            2'd0: w_dout_sel = fifo_dout_0;
            2'd1: w_dout_sel = fifo_dout_1;
            2'd2: w_dout_sel = fifo_dout_2;
            2'd3: w_dout_sel = fifo_dout_3;
            default: w_dout_sel = '0;
        endcase
    end

    always_ff @(posedge clk8f) begin
        if (!reset) begin
            r_state     <= ST_RESET;
            r_fifo_pop  <= '0;
            r_ptr       <= 2'd3;
            r_s1_vld    <= 1'b0;
            r_s1_lane   <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_lane_out  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fifo_pop  <= w_pop_nxt;
            r_ptr       <= w_ptr_nxt;
            // A live pop always leaves ptr pointing at the popped lane.
            r_s1_vld    <= |r_fifo_pop;
            r_s1_lane   <= r_ptr;
            r_valid_out <= r_s1_vld;
            r_data_out  <= r_s1_vld ? w_dout_sel : '0;
            r_lane_out  <= r_s1_vld ? r_s1_lane : '0;
        end
    end

    assign fifo_pop  = r_fifo_pop;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign lane_out  = r_lane_out;
    assign idle_out  = (r_state == ST_IDLE) && !r_s1_vld && !r_valid_out;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_LANES];

    always_ff @(posedge clk8f) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++)
                r_cnt[i] <= '0;
        end else if (r_s1_vld && (r_cnt[r_s1_lane] != {CNT_W{1'b1}})) begin
            r_cnt[r_s1_lane] <= r_cnt[r_s1_lane] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_stats
        assign stats_out[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: source FIFOs modelled as endless lanes whose word advances one cycle after each pop.
module tb_fifo_arbiter;

    logic        clk8f;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [7:0]  fifo_dout_0, fifo_dout_1, fifo_dout_2, fifo_dout_3;
    logic        dest_almost_full;
    logic [3:0]  fifo_pop;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_out;
    logic        idle_out;
`ifdef FIFO_ARB_STATS_EN
    logic [31:0] stats_out;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] dout [4];
    int         seq  [4];
    logic [3:0] pend;

    fifo_arbiter #(.DATA_W(8), .CNT_W(8)) dut (
        .clk8f            (clk8f),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_dout_0      (fifo_dout_0),
        .fifo_dout_1      (fifo_dout_1),
        .fifo_dout_2      (fifo_dout_2),
        .fifo_dout_3      (fifo_dout_3),
        .dest_almost_full (dest_almost_full),
        .fifo_pop         (fifo_pop),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .lane_out         (lane_out),
`ifdef FIFO_ARB_STATS_EN
        .idle_out         (idle_out),
        .stats_out        (stats_out)
`else
        .idle_out         (idle_out)
`endif
    );

    initial clk8f = 1'b0;
    always #5 clk8f = ~clk8f;

    assign fifo_dout_0 = dout[0];
    assign fifo_dout_1 = dout[1];
    assign fifo_dout_2 = dout[2];
    assign fifo_dout_3 = dout[3];

    // Word n of lane i is {i, 1, n[4:0]}; it appears in the cycle after its pop cycle.
    always @(negedge clk8f) begin
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                dout[i] = word(i, seq[i]);
                seq[i]  = seq[i] + 1;
            end
            pend[i] = fifo_pop[i];
        end
    end

    function automatic logic [7:0] word(input int lane, input int n);
        logic [1:0] l;
        logic [4:0] s;
        l = lane[1:0];
        s = n[4:0];
        return {l, 1'b1, s};
    endfunction

    task automatic tick();
        @(posedge clk8f);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fifo_empty = 4'hF;
        dest_almost_full = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            dout[i] = 8'h00;
        end
        pend = 4'h0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (fifo_pop !== 4'h0) begin bad++; $display("FAIL reset_pop got=%b exp=0000", fifo_pop); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
        total++; if (lane_out !== 2'd0) begin bad++; $display("FAIL reset_lane got=%0d exp=0", lane_out); end
        total++; if (idle_out !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", idle_out); end
        reset = 1'b1;
        tick();
        total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL reset_to_idle got=%b exp=1", idle_out); end
        tick();
        total++; if (idle_out !== 1'b1 || fifo_pop !== 4'h0) begin
            bad++; $display("FAIL idle_all_empty idle=%b pop=%b exp idle=1 pop=0000", idle_out, fifo_pop);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] ep;
        logic       ev;
        logic [1:0] el;
        logic [7:0] ed;
        do_reset();
        reset = 1'b1;
        fifo_empty = 4'b0000;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            ep = 4'(1 << (k % 4));
            ev = (k >= 2);
            el = ev ? 2'((k - 2) % 4) : 2'd0;
            ed = ev ? word((k - 2) % 4, (k - 2) / 4) : 8'h00;
            total++; if (fifo_pop !== ep) begin bad++; $display("FAIL rr_pop k=%0d got=%b exp=%b", k, fifo_pop, ep); end
            total++; if (valid_out !== ev || lane_out !== el || data_out !== ed) begin
                bad++; $display("FAIL rr_out k=%0d got v=%b l=%0d d=%h exp v=%b l=%0d d=%h", k, valid_out, lane_out, data_out, ev, el, ed);
            end
        end
    endtask

    task automatic test_single_lane();
        logic [3:0] ep;
        logic       ev;
        logic [1:0] el;
        logic [7:0] ed;
        logic [3:0] prev_pop;
        do_reset();
        reset = 1'b1;
        fifo_empty = 4'b1011;
        tick();
        tick();
        prev_pop = 4'h0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ep = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            ev = (k >= 2) && (k % 2 == 0);
            el = ev ? 2'd2 : 2'd0;
            ed = ev ? word(2, (k - 2) / 2) : 8'h00;
            total++; if (fifo_pop !== ep) begin bad++; $display("FAIL single_pop k=%0d got=%b exp=%b", k, fifo_pop, ep); end
            total++; if ((fifo_pop & prev_pop) !== 4'h0) begin bad++; $display("FAIL single_b2b k=%0d got=%b prev=%b exp no overlap", k, fifo_pop, prev_pop); end
            total++; if (valid_out !== ev || lane_out !== el || data_out !== ed) begin
                bad++; $display("FAIL single_out k=%0d got v=%b l=%0d d=%h exp v=%b l=%0d d=%h", k, valid_out, lane_out, data_out, ev, el, ed);
            end
            prev_pop = fifo_pop;
        end
    endtask

    task automatic test_stall();
        logic [3:0] ep [8];
        logic       ev [8];
        logic [1:0] el [8];
        logic [7:0] ed [8];
        ep = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1};
        ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        el = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
        ed = '{8'h20, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA0};
        do_reset();
        reset = 1'b1;
        fifo_empty = 4'b0000;
        tick();
        tick();
        tick();
        total++; if (fifo_pop !== 4'b0001) begin bad++; $display("FAIL stall_pre0 got=%b exp=0001", fifo_pop); end
        tick();
        total++; if (fifo_pop !== 4'b0010) begin bad++; $display("FAIL stall_pre1 got=%b exp=0010", fifo_pop); end
        dest_almost_full = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (fifo_pop !== ep[k]) begin bad++; $display("FAIL stall_pop k=%0d got=%b exp=%b", k, fifo_pop, ep[k]); end
            total++; if (valid_out !== ev[k] || lane_out !== el[k] || data_out !== ed[k]) begin
                bad++; $display("FAIL stall_out k=%0d got v=%b l=%0d d=%h exp v=%b l=%0d d=%h", k, valid_out, lane_out, data_out, ev[k], el[k], ed[k]);
            end
            total++; if (idle_out !== 1'b0) begin bad++; $display("FAIL stall_idle k=%0d got=%b exp=0", k, idle_out); end
            if (k == 3) dest_almost_full = 1'b0;
        end
    endtask

    task automatic test_two_lanes();
        logic [3:0] ep [6];
        logic       ev [6];
        logic [1:0] el [6];
        logic [7:0] ed [6];
        ep = '{4'h2, 4'h0, 4'h0, 4'h8, 4'h2, 4'h8};
        ev = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        el = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3};
        ed = '{8'h00, 8'h00, 8'h60, 8'h00, 8'h00, 8'hE0};
        do_reset();
        reset = 1'b1;
        fifo_empty = 4'b0101;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (fifo_pop !== ep[k]) begin bad++; $display("FAIL two_pop k=%0d got=%b exp=%b", k, fifo_pop, ep[k]); end
            total++; if (valid_out !== ev[k] || lane_out !== el[k] || data_out !== ed[k]) begin
                bad++; $display("FAIL two_out k=%0d got v=%b l=%0d d=%h exp v=%b l=%0d d=%h", k, valid_out, lane_out, data_out, ev[k], el[k], ed[k]);
            end
            if (k == 0) dest_almost_full = 1'b1;
            if (k == 1) dest_almost_full = 1'b0;
        end
    endtask

    task automatic test_drain();
        do_reset();
        reset = 1'b1;
        fifo_empty = 4'b1110;
        tick();
        tick();
        tick();
        total++; if (fifo_pop !== 4'b0001) begin bad++; $display("FAIL drain_pop got=%b exp=0001", fifo_pop); end
        fifo_empty = 4'hF;
        tick();
        total++; if (fifo_pop !== 4'h0 || idle_out !== 1'b0) begin
            bad++; $display("FAIL drain_e4 pop=%b idle=%b exp pop=0000 idle=0", fifo_pop, idle_out);
        end
        tick();
        total++; if (valid_out !== 1'b1 || data_out !== 8'h20 || idle_out !== 1'b0) begin
            bad++; $display("FAIL drain_e5 v=%b d=%h idle=%b exp v=1 d=20 idle=0", valid_out, data_out, idle_out);
        end
        tick();
        total++; if (valid_out !== 1'b0 || idle_out !== 1'b1) begin
            bad++; $display("FAIL drain_e6 v=%b idle=%b exp v=0 idle=1", valid_out, idle_out);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        reset = 1'b1;
        fifo_empty = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        total++; if (fifo_pop !== 4'b0010) begin bad++; $display("FAIL mid_pre got=%b exp=0010", fifo_pop); end
        reset = 1'b0;
        tick();
        total++; if (fifo_pop !== 4'h0 || valid_out !== 1'b0 || data_out !== 8'h00 || lane_out !== 2'd0 || idle_out !== 1'b0) begin
            bad++; $display("FAIL mid_reset pop=%b v=%b d=%h l=%0d idle=%b exp all 0", fifo_pop, valid_out, data_out, lane_out, idle_out);
        end
        reset = 1'b1;
        fifo_empty = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (valid_out !== 1'b0 || fifo_pop !== 4'h0) begin
                bad++; $display("FAIL mid_ghost k=%0d v=%b pop=%b exp v=0 pop=0000", k, valid_out, fifo_pop);
            end
        end
        total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b exp=1", idle_out); end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        int words;
        do_reset();
        total++; if (stats_out !== 32'h0) begin bad++; $display("FAIL stats_reset got=%h exp=0", stats_out); end
        reset = 1'b1;
        fifo_empty = 4'b1110;
        words = 0;
        for (int k = 0; k < 700 && words < 300; k++) begin
            tick();
            if (valid_out === 1'b1) words++;
        end
        fifo_empty = 4'hF;
        for (int k = 0; k < 4; k++) tick();
        total++; if (words < 300) begin bad++; $display("FAIL stats_words got=%0d exp=300", words); end
        total++; if (stats_out[7:0] !== 8'hFF) begin bad++; $display("FAIL stats_lane0 got=%0d exp=255", stats_out[7:0]); end
        total++; if (stats_out[31:8] !== 24'h0) begin bad++; $display("FAIL stats_others got=%h exp=0", stats_out[31:8]); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        fifo_empty = 4'hF;
        dest_almost_full = 1'b0;
        pend = 4'h0;
        for (int i = 0; i < 4; i++) begin
            seq[i]  = 0;
            dout[i] = 8'h00;
        end
        test_reset();
        test_round_robin();
        test_single_lane();
        test_stall();
        test_two_lanes();
        test_drain();
        test_reset_midflight();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, data word width.
REQ-002 Parameter CNT_W, default 8, width of each per-lane statistics counter.
REQ-003 clk8f  input  1  the only clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 fifo_empty  input  4  per-lane source-FIFO empty flag (bit i = lane i).
REQ-006 fifo_dout_0..fifo_dout_3  input  DATA_W each  source-FIFO read data, valid 1 cycle after the pop cycle.
REQ-007 dest_almost_full  input  1  downstream FIFO almost-full flag.
REQ-008 fifo_pop  output  4  registered one-hot pop, at most one bit high.
REQ-009 data_out  output  DATA_W  arbitrated word.
REQ-010 valid_out  output  1  data_out qualifier.
REQ-011 lane_out  output  2  source lane of the current data_out.
REQ-012 idle_out  output  1  high in IDLE with no word in flight.

Function
REQ-013 States SHALL be RESET, IDLE, ACTIVE and STALL, one-hot encoded.
REQ-014 RESET -> IDLE on the first edge with reset high.
REQ-015 IDLE -> ACTIVE when any fifo_empty bit is 0 and dest_almost_full=0.
REQ-016 ACTIVE -> STALL when dest_almost_full=1; ACTIVE -> IDLE when fifo_empty=4'b1111.
REQ-017 STALL -> ACTIVE when dest_almost_full=0 and any lane is non-empty; STALL -> IDLE when dest_almost_full=0 and no lane is non-empty.
REQ-018 Eligible lane: fifo_empty[i]=0, and i was not popped in the immediately preceding cycle (no-back-to-back rule, since empty flags lag one cycle).
REQ-019 In ACTIVE with dest_almost_full=0, the block SHALL assert fifo_pop for the first eligible lane searching ptr+1, ptr+2, ptr+3, ptr (mod 4), then set ptr to that lane.
REQ-020 With no eligible lane, fifo_pop SHALL be 0 and ptr unchanged; a single non-empty lane is therefore popped every other cycle.
REQ-021 No pop SHALL be issued in RESET, IDLE or STALL, or in any cycle where dest_almost_full=1.
REQ-022 Latency: pop registered at edge N -> data_out/valid_out/lane_out registered at edge N+2 from fifo_dout of the popped lane.
REQ-023 In-flight words (at most 2) SHALL still be delivered after dest_almost_full rises; downstream threshold SHALL leave >=2 free slots.
REQ-024 valid_out=0 cycles SHALL hold data_out at 0 and lane_out at 0.
REQ-025 idle_out=1 only when state=IDLE and both pipeline valid stages are 0.

Reset
REQ-026 reset=0 at an edge SHALL force state RESET, fifo_pop=0, data_out=0, valid_out=0, lane_out=0, idle_out=0, ptr=3 (lane 0 first), in-flight stages cleared.
REQ-027 Reset mid-operation SHALL discard in-flight words; no valid_out SHALL appear for pops issued before reset.

Configuration
REQ-028 Macro FIFO_ARB_STATS_EN defined: port stats_out (output, 4*CNT_W) SHALL exist, lane i count in bits [i*CNT_W +: CNT_W], incremented on each valid_out of lane i, saturating at all-ones, cleared by reset.
REQ-029 Macro undefined: no stats_out port and no counter logic; all other behaviour identical.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold state encodings, NUM_LANES=4 and LANE_W=2.
REQ-031 Combinational round-robin picker SHALL be sub-module rr_pick (inputs eligible[3:0], ptr[1:0]; outputs grant[3:0], grant_idx[1:0], any).

Verification
REQ-032 Reset release, fifo_empty=4'b0000, almost_full=0 -> pops 0001,0010,0100,1000,0001...; first valid_out 2 cycles after first pop, lane_out 0,1,2,3.
REQ-033 Only lane 2 non-empty (fifo_empty=4'b1011) -> fifo_pop alternates 0100/0000; never two consecutive pops of lane 2.
REQ-034 almost_full raised during ACTIVE -> next cycle fifo_pop=0, state STALL, exactly the in-flight words (<=2) still output; lowering it resumes at ptr+1.
REQ-035 Lanes 1,3 non-empty, ptr=1 -> next grant lane 3, then lane 1.
REQ-036 reset=0 with 2 words in flight -> valid_out=0 next edge, all outputs 0, no later delivery of those words.
REQ-037 With FIFO_ARB_STATS_EN, 300 lane-0 words -> lane 0 count saturates at 255 (CNT_W=8), others 0.
